// File: rtl/mem_dumper_if.sv
// ---------------------------------------------------------------------------
// mem_dumper_if
//
// Purpose:
//   Groups the request, memory read port and UART/status signals of the
//   memory dumper into one bundle.
//
// Signals:
//   START      single-cycle dump request
//   BASE       first address to dump
//   LEN        number of bytes to dump (0 .. 2^ADDR_WIDTH)
//   MEM_ADDR   registered read address towards the byte memory
//   MEM_RDATA  synchronous read data from the byte memory
//   UART_TXD   serial output, idles high
//   BUSY       dump in progress
//   DONE       one-cycle completion pulse
//
// Modports:
//   master  host + memory side (drives the request and the read data)
//   slave   dumper side
// ---------------------------------------------------------------------------
interface mem_dumper_if #(
    parameter int ADDR_WIDTH = 10
);

    logic                  START;
    logic [ADDR_WIDTH-1:0] BASE;
    logic [ADDR_WIDTH:0]   LEN;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic [7:0]            MEM_RDATA;
    logic                  UART_TXD;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        output START,
        output BASE,
        output LEN,
        output MEM_RDATA,
        input  MEM_ADDR,
        input  UART_TXD,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  BASE,
        input  LEN,
        input  MEM_RDATA,
        output MEM_ADDR,
        output UART_TXD,
        output BUSY,
        output DONE
    );

endinterface

// File: rtl/mem_dumper.sv
// ---------------------------------------------------------------------------
// mem_dumper
//
// Purpose:
//   Reads a contiguous range of the byte memory filled by the UART loader and
//   sends every byte back to the host as a UART 8N1 frame (LSB first).  The
//   block owns its baud counter and shift register, so it drives the board
//   TX pin directly.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   ADDR_WIDTH    memory address width, memory depth is 2^ADDR_WIDTH
//
// Ports:
//   CLK   system clock, rising edge
//   RST   asynchronous active-high reset
//   bus   mem_dumper_if slave modport:
//           START/BASE/LEN   dump request, BASE/LEN latched on acceptance
//           MEM_ADDR         registered read address, stable for a frame
//           MEM_RDATA        read data, valid one cycle after MEM_ADDR
//           UART_TXD         serial output
//           BUSY/DONE        status
// ---------------------------------------------------------------------------
module mem_dumper #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic         CLK,
    input  logic         RST,
    mem_dumper_if.slave  bus
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA,
        STOP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [ADDR_WIDTH:0]   remaining_d;
    logic [7:0]            shift_q;
    logic [7:0]            shift_d;
    logic [2:0]            bit_cnt_q;
    logic [2:0]            bit_cnt_d;
    logic [BAUD_W-1:0]     baud_q;
    logic [BAUD_W-1:0]     baud_d;
    logic                  txd_q;
    logic                  txd_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  bit_end;
    logic                  last_byte;
    logic                  start_ok;
    logic                  start_empty;

    // A bit period ends on the last count of the baud counter.
    assign bit_end     = (baud_q == BAUD_LAST);
    assign last_byte   = (remaining_q == (ADDR_WIDTH + 1)'(1));
    assign start_ok    = bus.START && (bus.LEN != '0);
    assign start_empty = bus.START && (bus.LEN == '0);

    // State register and all datapath registers.  TXD resets high so the
    // line returns to idle the moment reset is asserted, even mid-frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            baud_q      <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            baud_q      <= baud_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.  A LEN=0 request never leaves IDLE; it only pulses
    // DONE.  STOP either fetches the next byte or finishes the dump.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                state_d = START_BIT;
            end
            START_BIT: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_cnt_q == 3'd7)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = last_byte ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values.  FETCH only gives the memory a cycle
    // to sample MEM_ADDR; LOAD grabs the read data and drops TXD for the
    // start bit.  In DATA the bit after the current one is shift_q[1],
    // because the shift and the TXD update happen on the same edge.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        baud_d      = baud_q;
        txd_d       = txd_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (start_ok) begin
                    remaining_d = bus.LEN;
                    mem_addr_d  = bus.BASE;
                    busy_d      = 1'b1;
                end else if (start_empty) begin
                    done_d = 1'b1;
                end
            end
            FETCH: begin
                txd_d = 1'b1;
            end
            LOAD: begin
                shift_d   = bus.MEM_RDATA;
                txd_d     = 1'b0;
                baud_d    = '0;
                bit_cnt_d = '0;
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_d = '0;
                    txd_d  = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    txd_d     = (bit_cnt_q == 3'd7) ? 1'b1 : shift_q[1];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d      = '0;
                    remaining_d = remaining_q - 1'b1;
                    if (last_byte) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        // Natural overflow wraps the address at the top of memory.
                        mem_addr_d = mem_addr_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                txd_d = 1'b1;
            end
        endcase
    end

    assign bus.MEM_ADDR = mem_addr_q;
    assign bus.UART_TXD = txd_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;

endmodule

// File: doc/mem_dumper.md
# mem_dumper

Reads a contiguous range of the byte memory filled by the UART loader and transmits each byte back to the host as a UART 8N1 frame (LSB first) on UART_TXD. It lets the host verify or dump loaded program/data images. It sits beside the loader on the same 1024×8 memory, using a separate synchronous read port, and drives the board UART TX pin. It contains its own baud counter and shift register, so no external transmitter is needed.

## Interface
Parameters:
- CLKS_PER_BIT, default 10417: clock cycles per UART bit (9600 baud at 100 MHz); legal range ≥ 4.
- ADDR_WIDTH, default 10: memory address width; the memory depth is 2^ADDR_WIDTH.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- START  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- BASE  in  ADDR_WIDTH  first address to dump; latched when START is accepted.
- LEN  in  ADDR_WIDTH+1  number of bytes to dump, 0..2^ADDR_WIDTH; latched when START is accepted.
- MEM_ADDR  out  ADDR_WIDTH  registered read address to the memory.
- MEM_RDATA  in  8  read data from the memory; valid one cycle after MEM_ADDR is sampled (synchronous read).
- UART_TXD  out  1  serial output; idles high.
- BUSY  out  1  high from START acceptance until the last stop bit completes.
- DONE  out  1  one-cycle pulse when the dump completes.

## Operation
- Reset values: state IDLE, UART_TXD=1, BUSY=0, DONE=0, MEM_ADDR=0, bit counter=0, baud counter=0, remaining=0.
- States:
  - IDLE: TXD=1.
    - START=1 and LEN≠0: latch LEN into remaining, set MEM_ADDR<=BASE, BUSY<=1, go to FETCH.
    - START=1 and LEN=0: DONE<=1 for one cycle; BUSY stays 0; no frame is sent.
  - FETCH: one cycle, during which the memory samples MEM_ADDR. Go to LOAD.
  - LOAD: capture MEM_RDATA into the shift register, TXD<=0, clear the baud counter, go to START_BIT.
  - START_BIT: hold TXD=0 for CLKS_PER_BIT cycles. Then TXD<=shift[0] and go to DATA.
  - DATA: each CLKS_PER_BIT cycles, shift right and increment the bit counter. After the 8th bit period, TXD<=1 and go to STOP.
  - STOP: hold TXD=1 for CLKS_PER_BIT cycles. Then decrement remaining.
    - remaining was 1: go to IDLE, BUSY<=0, DONE<=1.
    - Otherwise: MEM_ADDR<=MEM_ADDR+1 (wraps modulo 2^ADDR_WIDTH) and go to FETCH.
- Baud counter counts 0..CLKS_PER_BIT-1, and a bit period ends when it reaches CLKS_PER_BIT-1.
- START while BUSY=1 is ignored; it is neither queued nor allowed to alter the latched BASE/LEN.
- BASE/LEN changes after acceptance have no effect.
- Address wrap: BASE=2^ADDR_WIDTH-1 with LEN≥2 continues at address 0.
- LEN=2^ADDR_WIDTH dumps the whole memory once, ending at BASE-1.
- RST mid-frame: TXD goes to 1 immediately (asynchronously) and BUSY=0. DONE is not pulsed and the partial frame is abandoned.

## Timing
- Edge E0 samples START in IDLE.
  - MEM_ADDR=BASE after E0.
  - Memory samples it at E1.
  - TXD falls after E2: a latency of 3 cycles from START to the start bit.
- Frame length is exactly 10×CLKS_PER_BIT cycles: 1 start, 8 data LSB first, 1 stop.
- Inter-frame gap is 2 extra idle-high cycles (FETCH+LOAD), so consecutive frames start 10×CLKS_PER_BIT+2 cycles apart.
- BUSY rises after E0 and falls in the same cycle DONE is high. That is 3+LEN×(10×CLKS_PER_BIT)+2×(LEN−1) cycles after E0 (LEN≠0).
- DONE is high for exactly one cycle. For LEN=0 it is the cycle after E0.
- MEM_ADDR is stable for the whole frame and only changes after the stop bit.

## Test plan
Benches use CLKS_PER_BIT=16 and a behavioural 1024×8 synchronous-read memory.
- Single byte:
  - Stimulus: mem[5]=0x55, BASE=5, LEN=1, pulse START.
  - Response: TXD low 3 cycles after START, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then stop high.
  - DONE pulses once, 163 cycles after START. BUSY spans the same window.
- Multi-byte with wrap:
  - Stimulus: mem[1023]=0xA1, mem[0]=0x3C, mem[1]=0xFF, BASE=1023, LEN=3.
  - Response: a UART sampler decodes A1,3C,FF in order. Frame starts are 162 cycles apart.
- LEN=0:
  - Stimulus: pulse START with LEN=0.
  - Response: DONE pulses the next cycle, BUSY stays 0, TXD stays 1 throughout.
- START while busy:
  - Stimulus: second START pulse with a different BASE during byte 1 of LEN=2.
  - Response: output is exactly the two original bytes, with a single DONE.
- Reset mid-frame:
  - Stimulus: assert RST during data bit 4, asynchronously between edges.
  - Response: TXD=1 and BUSY=0 before the next edge, no DONE pulse.
  - A fresh START after release produces a clean, correct frame.
- Full memory:
  - Stimulus: mem[i]=i[7:0], BASE=0x200, LEN=1024.
  - Response: 1024 bytes decoded, starting at 0x00 (mem[0x200]), wrapping at 1023→0, last byte 0xFF (mem[0x1FF]).
